mp3_display_timing: RTL and testbench
=====================================

Name: mp3_display_timing

Overview:
- Raster timing generator that drives the pixel-coordinate side of the MP3 player display path.
- Produces signed 16-bit pixel coordinates (o_sx, o_sy) consumed by the display renderer, plus hsync, vsync and data-enable for the video output.
- Coordinates are negative during blanking and 0..RES-1 during the active area.
- Delayed sync and data-enable copies let the registered RGB output stay aligned with sync.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- SYNC_DLY, 1, pipeline depth of the delayed outputs (0..4)

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous, active-low reset
- o_sx  output  16  signed horizontal coordinate
- o_sy  output  16  signed vertical coordinate
- o_de  output  1  active-area flag, aligned with o_sx/o_sy
- o_hsync  output  1  horizontal sync, aligned with o_sx/o_sy
- o_vsync  output  1  vertical sync, aligned with o_sx/o_sy
- o_frame  output  1  1-cycle pulse at (H_STA, V_STA)
- o_line  output  1  1-cycle pulse at sx == H_STA, every line
- o_frame_cnt  output  16  frames completed, wraps at 16'hFFFF -> 0
- o_de_d, o_hsync_d, o_vsync_d  output  1 each  copies delayed SYNC_DLY cycles

Behaviour:
- Derived constants: H_STA = -(H_FP+H_SYNC+H_BP) and V_STA = -(V_FP+V_SYNC+V_BP). Defaults give H_STA = -160, V_STA = -45, 800 clocks/line, 525 lines/frame.
- sx counts H_STA..H_RES-1. At H_RES-1 it wraps to H_STA and sy advances.
- sy counts V_STA..V_RES-1. At (H_RES-1, V_RES-1) both wrap to the start values and o_frame_cnt increments.
- All outputs are registered. Flags are computed from the next counter values, so each flag describes the o_sx/o_sy presented in the same cycle.
- hsync is active for sx in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1]. Defaults: -144..-49.
- vsync is active for sy in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1]. Defaults: -35..-34.
- vsync is line-based: it changes only at sx == H_STA.
- Inactive sync level is ~POL.
- o_de = (sx >= 0) & (sy >= 0), evaluated as a signed compare.
- Delayed outputs: shift register of depth SYNC_DLY. SYNC_DLY = 0 makes them equal the undelayed outputs.
- Reset (asynchronous, any point mid-frame):
  - o_sx = H_STA, o_sy = V_STA, o_frame_cnt = 0.
  - o_de = 0, o_line = 0.
  - o_frame = 1, since reset lands on the frame start.
  - Syncs at the inactive level.
  - Delay stages flushed to inactive (de 0, syncs ~POL).
- First rising edge after reset release: o_sx = H_STA+1.
- No other state. Timing is free-running; there is no handshake.

Optional Feature:
- Macro: MP3_TIMING_CE_EN.
- Defined:
  - Adds input port i_ce (1 bit), placed after rst_n.
  - Counters, o_frame_cnt and the delay stages advance only on cycles where i_ce = 1. All outputs hold while i_ce = 0.
  - o_frame and o_line assert for exactly one i_ce-qualified cycle: they fall on the next i_ce = 1 cycle, and stay high while i_ce is low.
  - Used to run from 100 MHz with a /4 strobe.
- Undefined: no i_ce port; advance every clk.

Test Plan:
- Reset release, defaults -> o_sx = -160, o_sy = -45, o_frame = 1. After 1 clk: o_sx = -159, o_frame = 0. After 800 clks: o_sx = -160, o_sy = -44, o_line = 1.
- One full line -> o_hsync low for exactly 96 consecutive clocks, starting at o_sx = -144. o_de high for exactly 640 clocks, o_sx = 0..639, only when o_sy >= 0.
- One full frame (420000 clocks) -> o_vsync low for exactly 1600 clocks (o_sy = -35, -34). o_frame pulses once. o_frame_cnt goes 0 -> 1 at the wrap from (639, 479) to (-160, -45).
- SYNC_DLY = 2 -> o_hsync_d, o_vsync_d, o_de_d each equal their undelayed signal shifted exactly 2 clocks. SYNC_DLY = 0 -> identical to the undelayed signals.
- Assert rst_n low at o_sx = 300, o_sy = 200, asynchronously mid-cycle -> outputs take reset values immediately, without waiting for clk: o_de = 0, syncs high, o_frame_cnt = 0. Counting restarts at -160/-45.
- MP3_TIMING_CE_EN defined, i_ce = 1 every 4th clk -> o_sx increments once per 4 clks. One line = 3200 clks. o_line stays high for 4 clks: it falls on the next i_ce strobe.

Source files
------------

// File: rtl/mp3_display_timing.sv
// rtl/mp3_display_timing.sv - raster timing generator for the MP3 player display path
//
// Purpose:
//   Free-running pixel/line counters with signed coordinates. Coordinates are
//   negative during blanking and 0..RES-1 in the active area. Syncs, data
//   enable and the frame/line pulses are registered and aligned with o_sx/o_sy.
//   Delayed copies of de/hsync/vsync let a registered RGB stage stay aligned.
//
// Optional feature (macro MP3_TIMING_CE_EN):
//   Adds input i_ce. All state advances only on cycles with i_ce = 1.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   i_ce         clock enable (only with MP3_TIMING_CE_EN)
//   o_sx, o_sy   signed 16-bit pixel coordinates
//   o_de         active-area flag
//   o_hsync      horizontal sync (active level H_POL)
//   o_vsync      vertical sync (active level V_POL)
//   o_frame      one-cycle pulse at (H_STA, V_STA)
//   o_line       one-cycle pulse at sx == H_STA
//   o_frame_cnt  completed frames, wraps
//   o_de_d, o_hsync_d, o_vsync_d  copies delayed SYNC_DLY cycles

module mp3_display_timing #(
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int SYNC_DLY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef MP3_TIMING_CE_EN
   input  logic               i_ce,
`endif
   output logic signed [15:0] o_sx,
   output logic signed [15:0] o_sy,
   output logic               o_de,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_frame,
   output logic               o_line,
   output logic [15:0]        o_frame_cnt,
   output logic               o_de_d,
   output logic               o_hsync_d,
   output logic               o_vsync_d
);

   localparam logic signed [15:0] H_STA  = 16'(-(H_FP + H_SYNC + H_BP));
   localparam logic signed [15:0] V_STA  = 16'(-(V_FP + V_SYNC + V_BP));
   localparam logic signed [15:0] H_LAST = 16'(H_RES - 1);
   localparam logic signed [15:0] V_LAST = 16'(V_RES - 1);
   // Sync windows expressed relative to the end of blanking (H_STA + FP = -(SYNC + BP)).
   localparam logic signed [15:0] HS_BEG = 16'(-(H_SYNC + H_BP));
   localparam logic signed [15:0] HS_END = 16'(-H_BP - 1);
   localparam logic signed [15:0] VS_BEG = 16'(-(V_SYNC + V_BP));
   localparam logic signed [15:0] VS_END = 16'(-V_BP - 1);
   localparam logic HS_ON = (H_POL != 0);
   localparam logic VS_ON = (V_POL != 0);

   logic               w_ce;
   logic               w_h_end;
   logic               w_v_end;
   logic signed [15:0] w_sx_nxt;
   logic signed [15:0] w_sy_nxt;

   logic signed [15:0] r_sx;
   logic signed [15:0] r_sy;
   logic [15:0]        r_frame_cnt;
   logic               r_de;
   logic               r_hs;
   logic               r_vs;
   logic               r_frame;
   logic               r_line;

`ifdef MP3_TIMING_CE_EN
   assign w_ce = i_ce;
`else
   assign w_ce = 1'b1;
`endif

   assign w_h_end  = (r_sx == H_LAST);
   assign w_v_end  = (r_sy == V_LAST);
   assign w_sx_nxt = w_h_end ? H_STA : r_sx + 16'sd1;
   assign w_sy_nxt = w_h_end ? (w_v_end ? V_STA : r_sy + 16'sd1) : r_sy;

   // Flags are derived from the next coordinates so that, once registered,
   // they describe the coordinates presented in the same cycle. vsync only
   // moves when sy moves, which happens exactly at sx == H_STA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sx        <= H_STA;
         r_sy        <= V_STA;
         r_frame_cnt <= 16'd0;
         r_de        <= 1'b0;
         r_hs        <= ~HS_ON;
         r_vs        <= ~VS_ON;
         r_frame     <= 1'b1;
         r_line      <= 1'b0;
      end else if (w_ce) begin
         r_sx    <= w_sx_nxt;
         r_sy    <= w_sy_nxt;
         r_de    <= (w_sx_nxt >= 16'sd0) && (w_sy_nxt >= 16'sd0);
         r_hs    <= ((w_sx_nxt >= HS_BEG) && (w_sx_nxt <= HS_END)) ? HS_ON : ~HS_ON;
         r_vs    <= ((w_sy_nxt >= VS_BEG) && (w_sy_nxt <= VS_END)) ? VS_ON : ~VS_ON;
         r_frame <= (w_sx_nxt == H_STA) && (w_sy_nxt == V_STA);
         r_line  <= (w_sx_nxt == H_STA);
         if (w_h_end && w_v_end) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign o_sx        = r_sx;
   assign o_sy        = r_sy;
   assign o_de        = r_de;
   assign o_hsync     = r_hs;
   assign o_vsync     = r_vs;
   assign o_frame     = r_frame;
   assign o_line      = r_line;
   assign o_frame_cnt = r_frame_cnt;

   generate
      if (SYNC_DLY == 0) begin : g_no_dly
         assign o_de_d    = r_de;
         assign o_hsync_d = r_hs;
         assign o_vsync_d = r_vs;
      end else begin : g_dly
         logic [SYNC_DLY-1:0] r_de_sr;
         logic [SYNC_DLY-1:0] r_hs_sr;
         logic [SYNC_DLY-1:0] r_vs_sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_de_sr <= '0;
               r_hs_sr <= {SYNC_DLY{~HS_ON}};
               r_vs_sr <= {SYNC_DLY{~VS_ON}};
            end else if (w_ce) begin
               r_de_sr[0] <= r_de;
               r_hs_sr[0] <= r_hs;
               r_vs_sr[0] <= r_vs;
               for (int i = 1; i < SYNC_DLY; i++) begin
                  r_de_sr[i] <= r_de_sr[i-1];
                  r_hs_sr[i] <= r_hs_sr[i-1];
                  r_vs_sr[i] <= r_vs_sr[i-1];
               end
            end
         end

         assign o_de_d    = r_de_sr[SYNC_DLY-1];
         assign o_hsync_d = r_hs_sr[SYNC_DLY-1];
         assign o_vsync_d = r_vs_sr[SYNC_DLY-1];
      end
   endgenerate

endmodule

// File: tb/tb_mp3_display_timing.sv
// tb/tb_mp3_display_timing.sv - self-checking bench for mp3_display_timing
module tb_mp3_display_timing;

   typedef struct packed {
      int h_res; int v_res; int h_fp; int h_sync; int h_bp;
      int v_fp; int v_sync; int v_bp; int h_pol; int v_pol;
   } cfg_t;

   typedef struct {
      int sx; int sy; int fcnt;
      bit de; bit hs; bit vs; bit frame; bit line;
   } exp_t;

   // Small raster for A (231 clocks/frame), default VGA raster for B.
   localparam cfg_t CA = '{12, 6, 2, 3, 4, 1, 2, 2, 1, 0};
   localparam cfg_t CB = '{640, 480, 16, 96, 48, 10, 2, 33, 0, 0};
   localparam int DLY_A = 2;
   localparam int DLY_B = 0;

   int     n_tests = 0;
   int     n_fail  = 0;
   longint ta = 0;
   longint tb = 0;

   logic clk = 1'b0;
   logic rst_a, rst_b, ce;
   always #5 clk = ~clk;

   logic signed [15:0] a_sx, a_sy, b_sx, b_sy;
   logic [15:0] a_fc, b_fc;
   logic a_de, a_hs, a_vs, a_fr, a_ln, a_ded, a_hsd, a_vsd;
   logic b_de, b_hs, b_vs, b_fr, b_ln, b_ded, b_hsd, b_vsd;

   mp3_display_timing #(
      .H_RES(12), .V_RES(6), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_FP(1), .V_SYNC(2), .V_BP(2), .H_POL(1), .V_POL(0), .SYNC_DLY(DLY_A)
   ) u_a (
      .clk(clk), .rst_n(rst_a),
`ifdef MP3_TIMING_CE_EN
      .i_ce(ce),
`endif
      .o_sx(a_sx), .o_sy(a_sy), .o_de(a_de), .o_hsync(a_hs), .o_vsync(a_vs),
      .o_frame(a_fr), .o_line(a_ln), .o_frame_cnt(a_fc),
      .o_de_d(a_ded), .o_hsync_d(a_hsd), .o_vsync_d(a_vsd)
   );

   mp3_display_timing #(.SYNC_DLY(DLY_B)) u_b (
      .clk(clk), .rst_n(rst_b),
`ifdef MP3_TIMING_CE_EN
      .i_ce(ce),
`endif
      .o_sx(b_sx), .o_sy(b_sy), .o_de(b_de), .o_hsync(b_hs), .o_vsync(b_vs),
      .o_frame(b_fr), .o_line(b_ln), .o_frame_cnt(b_fc),
      .o_de_d(b_ded), .o_hsync_d(b_hsd), .o_vsync_d(b_vsd)
   );

   // Expected outputs t advancing edges after reset release; t < 0 means the
   // delay line still holds its flushed (inactive) reset contents.
   function automatic exp_t model(cfg_t c, longint t);
      exp_t   e;
      int     ht, vt, hsta, vsta;
      longint pos;
      ht   = c.h_res + c.h_fp + c.h_sync + c.h_bp;
      vt   = c.v_res + c.v_fp + c.v_sync + c.v_bp;
      hsta = -(c.h_fp + c.h_sync + c.h_bp);
      vsta = -(c.v_fp + c.v_sync + c.v_bp);
      if (t < 0) begin
         e.sx = hsta; e.sy = vsta; e.fcnt = 0; e.de = 0;
         e.hs = (c.h_pol == 0); e.vs = (c.v_pol == 0); e.frame = 1; e.line = 0;
         return e;
      end
      pos    = t % (ht * vt);
      e.sx   = hsta + int'(pos % ht);
      e.sy   = vsta + int'(pos / ht);
      e.fcnt = int'((t / (ht * vt)) % 65536);
      e.de   = (e.sx >= 0) && (e.sy >= 0);
      e.hs   = (e.sx >= hsta + c.h_fp && e.sx < hsta + c.h_fp + c.h_sync) ? (c.h_pol != 0) : (c.h_pol == 0);
      e.vs   = (e.sy >= vsta + c.v_fp && e.sy < vsta + c.v_fp + c.v_sync) ? (c.v_pol != 0) : (c.v_pol == 0);
      e.frame = (pos == 0);
      e.line  = (pos % ht == 0) && (t != 0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic check_out(input string nm, input exp_t e, input exp_t d,
                            input logic signed [15:0] sx, input logic signed [15:0] sy,
                            input logic [15:0] fc, input logic de, input logic hs,
                            input logic vs, input logic fr, input logic ln,
                            input logic ded, input logic hsd, input logic vsd);
      chk({nm, ".sx"}, sx, e.sx);
      chk({nm, ".sy"}, sy, e.sy);
      chk({nm, ".frame_cnt"}, fc, e.fcnt);
      chk({nm, ".de"}, de, e.de);
      chk({nm, ".hsync"}, hs, e.hs);
      chk({nm, ".vsync"}, vs, e.vs);
      chk({nm, ".frame"}, fr, e.frame);
      chk({nm, ".line"}, ln, e.line);
      chk({nm, ".de_d"}, ded, d.de);
      chk({nm, ".hsync_d"}, hsd, d.hs);
      chk({nm, ".vsync_d"}, vsd, d.vs);
   endtask

   task automatic check_a(input longint t);
      check_out("A", model(CA, t), model(CA, t - DLY_A), a_sx, a_sy, a_fc,
                a_de, a_hs, a_vs, a_fr, a_ln, a_ded, a_hsd, a_vsd);
   endtask

   task automatic check_b(input longint t);
      check_out("B", model(CB, t), model(CB, t - DLY_B), b_sx, b_sy, b_fc,
                b_de, b_hs, b_vs, b_fr, b_ln, b_ded, b_hsd, b_vsd);
   endtask

   task automatic run_a(input int n);
      repeat (n) begin
         @(posedge clk); ta++;
         @(negedge clk); check_a(ta);
      end
   endtask

   task automatic run_b(input int n);
      repeat (n) begin
         @(posedge clk); tb++;
         @(negedge clk); check_b(tb);
      end
   endtask

   // Asynchronous reset a few ns after a falling edge, checked before the next
   // rising edge, then held for a random number of cycles and released.
   task automatic mid_reset_a(input int hold);
      #($urandom_range(1, 3));
      rst_a = 1'b0;
      #1 check_a(0);
      repeat (hold + 1) begin
         @(negedge clk); check_a(0);
      end
      rst_a = 1'b1;
      ta = 0;
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      ce    = 1'b1;
      repeat (2) @(negedge clk);
      check_a(0);
      check_b(0);

      // A: reach (sx=5, sy=3) and reset there mid-frame.
      rst_a = 1'b1; ta = 0;
      run_a(182);
      chk("A.pos_before_reset_sx", a_sx, 5);
      chk("A.pos_before_reset_sy", a_sy, 3);
      mid_reset_a(0);
      // Several full frames, covering frame_cnt and frame wraps.
      run_a(3 * 231 + 7);

      // A: random run lengths separated by random asynchronous resets.
      for (int it = 0; it < 15; it++) begin
         run_a(int'($urandom_range(1, 700)));
         mid_reset_a(int'($urandom_range(0, 2)));
      end
      run_a(50);
      rst_a = 1'b0;

      // B: default VGA timing, two lines plus, then reset mid-line and rerun.
      @(negedge clk);
      rst_b = 1'b1; tb = 0;
      run_b(1900 + int'($urandom_range(0, 300)));
      #2 rst_b = 1'b0;
      #1 check_b(0);
      @(negedge clk); check_b(0);
      rst_b = 1'b1; tb = 0;
      run_b(900);

`ifdef MP3_TIMING_CE_EN
      // A with a /4 enable strobe: state moves only on qualified edges.
      rst_a = 1'b0;
      @(negedge clk); check_a(0);
      rst_a = 1'b1; ta = 0;
      for (int k = 0; k < 4 * 500; k++) begin
         ce = (k % 4 == 0);
         @(posedge clk);
         if (ce) ta++;
         @(negedge clk); check_a(ta);
      end
      ce = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
